// File: rtl/vga_ball_render_if.sv
// vga_ball_render_if: ball state from the PS/2 controller in, VGA pins and frame marker out.
interface vga_ball_render_if;
    logic [10:0] ball_x;
    logic [10:0] ball_y;
    logic [2:0]  radius;
    logic [1:0]  color;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_r;
    logic        vga_g;
    logic        vga_b;
    logic        frame_start;
    modport master (
        output ball_x, ball_y, radius, color,
        input  vga_hsync, vga_vsync, vga_r, vga_g, vga_b, frame_start
    );
    modport slave (
        input  ball_x, ball_y, radius, color,
        output vga_hsync, vga_vsync, vga_r, vga_g, vga_b, frame_start
    );
endinterface

// File: rtl/vga_ball_render.sv
// vga_ball_render: 640x480@60 VGA timing with a once-per-frame ball snapshot and a
// 3-stage offset/square/compare pixel pipeline; syncs ride the same pipeline.
module vga_ball_render #(
    parameter int CLK_DIV = 2,
    parameter int R_STEP  = 5,
    parameter int PLAY_X0 = 50,
    parameter int PLAY_X1 = 590,
    parameter int PLAY_Y0 = 50,
    parameter int PLAY_Y1 = 430
) (
    input logic              CLK,
    input logic              reset,
    vga_ball_render_if.slave bus
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [9:0] X0 = 10'(PLAY_X0);
    localparam logic [9:0] X1 = 10'(PLAY_X1);
    localparam logic [9:0] Y0 = 10'(PLAY_Y0);
    localparam logic [9:0] Y1 = 10'(PLAY_Y1);

    logic [DW-1:0]      div;
    logic [9:0]         h_cnt, v_cnt;
    logic [10:0]        snap_x, snap_y;
    logic [2:0]         snap_radius;
    logic [1:0]         snap_color;
    logic [10:0]        s1_adx, s1_ady;
    logic [5:0]         s1_r;
    logic [3:0]         s1_f, s2_f;
    logic [21:0]        s2_dx2, s2_dy2;
    logic [11:0]        s2_r2;
    logic               pix_tick, h_last, v_last, snap, in_ball;
    logic signed [11:0] dx, dy;
    logic [10:0]        adx, ady;
    logic [3:0]         f_raw;
    logic [22:0]        dist2;
    logic [2:0]         col_rgb, rgb_next;

    always_comb begin
        pix_tick = div == DW'(CLK_DIV - 1);
        h_last   = h_cnt == 10'd799;
        v_last   = v_cnt == 10'd524;
        snap     = pix_tick && h_cnt == 10'd0 && v_cnt == 10'd490;
        dx       = {2'b00, h_cnt} - {1'b0, snap_x};
        dy       = {2'b00, v_cnt} - {1'b0, snap_y};
        adx      = dx[11] ? 11'(-dx) : dx[10:0];
        ady      = dy[11] ? 11'(-dy) : dy[10:0];
        // flag order: {vis, border, hsync, vsync}
        f_raw    = {h_cnt < 10'd640 && v_cnt < 10'd480,
                    !(h_cnt >= X0 && h_cnt < X1 && v_cnt >= Y0 && v_cnt < Y1),
                    !(h_cnt >= 10'd656 && h_cnt < 10'd752),
                    !(v_cnt >= 10'd490 && v_cnt < 10'd492)};
        dist2    = {1'b0, s2_dx2} + {1'b0, s2_dy2};
        in_ball  = dist2 <= {11'b0, s2_r2};
        col_rgb  = {snap_color == 2'd1, snap_color == 2'd2, snap_color == 2'd3};
        rgb_next = !s2_f[3] ? 3'b000 : in_ball ? col_rgb : s2_f[2] ? 3'b111 : 3'b000;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            div             <= '0;
            h_cnt           <= '0;
            v_cnt           <= '0;
            snap_x          <= 11'd320;
            snap_y          <= 11'd240;
            snap_radius     <= '0;
            snap_color      <= 2'd1;
            s1_adx          <= '0;
            s1_ady          <= '0;
            s1_r            <= '0;
            s1_f            <= 4'b0011;
            s2_dx2          <= '0;
            s2_dy2          <= '0;
            s2_r2           <= '0;
            s2_f            <= 4'b0011;
            bus.vga_hsync   <= 1'b1;
            bus.vga_vsync   <= 1'b1;
            bus.vga_r       <= 1'b0;
            bus.vga_g       <= 1'b0;
            bus.vga_b       <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            div             <= pix_tick ? '0 : div + 1'b1;
            bus.frame_start <= snap;
            if (snap) begin
                snap_x      <= bus.ball_x;
                snap_y      <= bus.ball_y;
                snap_radius <= bus.radius;
                snap_color  <= bus.color;
            end
            if (pix_tick) begin
                h_cnt  <= h_last ? '0 : h_cnt + 1'b1;
                if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                s1_adx <= adx;
                s1_ady <= ady;
                s1_r   <= 6'(snap_radius * R_STEP);
                s1_f   <= f_raw;
                s2_dx2 <= 22'(s1_adx) * 22'(s1_adx);
                s2_dy2 <= 22'(s1_ady) * 22'(s1_ady);
                s2_r2  <= 12'(s1_r) * 12'(s1_r);
                s2_f   <= s1_f;
                {bus.vga_r, bus.vga_g, bus.vga_b} <= rgb_next;
                bus.vga_hsync <= s2_f[1];
                bus.vga_vsync <= s2_f[0];
            end
        end
    end
endmodule
